gradient_scanner: RTL and testbench



---
 rtl/gradient_pkg.sv | 72 +++++++
 rtl/gradient_scanner_vga_timing.sv | 64 ++++++
 rtl/gradient_scanner.sv | 105 ++++++++++
 tb/tb_gradient_scanner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared timing constants, pattern encodings and the registered output bundle
// for the gradient display scan front end.
package gradient_pkg;

  localparam int CNT_W   = 10;
  localparam int LEVEL_W = 6;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [1:0] MODE_VERT  = 2'd0;
  localparam logic [1:0] MODE_HORIZ = 2'd1;
  localparam logic [1:0] MODE_DIAG  = 2'd2;
  localparam logic [1:0] MODE_FLAT  = 2'd3;

  typedef struct packed {
    logic [LEVEL_W:0] grad_y;
    logic [1:0]       grad_x;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             frame_tick;
  } pix_out_t;

  // Blanked, syncs deasserted (high), no tick.
  localparam pix_out_t PIX_RST = '{
    grad_y:     '0,
    grad_x:     '0,
    de:         1'b0,
    hsync:      1'b1,
    vsync:      1'b1,
    frame_tick: 1'b0
  };

  // Gradient level for one beam position; every add truncates to 6 bits.
  function automatic logic [LEVEL_W-1:0] calc_level(
    input logic [1:0]         mode,
    input logic [CNT_W-1:0]   hpos,
    input logic [CNT_W-1:0]   vpos,
    input logic [LEVEL_W-1:0] offset
  );
    logic [LEVEL_W-1:0] h_band;
    logic [LEVEL_W-1:0] v_fine;
    logic [LEVEL_W-1:0] v_band;
    logic [LEVEL_W-1:0] lvl;
    h_band = LEVEL_W'(hpos >> 4);
    v_fine = LEVEL_W'(vpos >> 3);
    v_band = LEVEL_W'(vpos >> 4);
    case (mode)
      MODE_VERT:  lvl = v_fine + offset;
      MODE_HORIZ: lvl = h_band + offset;
      MODE_DIAG:  lvl = h_band + v_band + offset;
      default:    lvl = offset;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/gradient_scanner_vga_timing.sv
// Beam position counters with active-area, sync and frame-boundary decode.
// Decodes are combinational from the counter state; the top registers them.
module vga_timing
  import gradient_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SW    = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             fb,
  output logic             first
);

  localparam int HT = H_ACT + H_FRONT + H_SW + H_BACK;
  localparam int VT = V_ACT + V_FRONT + V_SW + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_FROM = CNT_W'(H_ACT + H_FRONT);
  localparam logic [CNT_W-1:0] HS_TO   = CNT_W'(H_ACT + H_FRONT + H_SW);
  localparam logic [CNT_W-1:0] VS_FROM = CNT_W'(V_ACT + V_FRONT);
  localparam logic [CNT_W-1:0] VS_TO   = CNT_W'(V_ACT + V_FRONT + V_SW);

  logic h_last;
  logic v_last;

  assign h_last = (hpos == H_LAST);
  assign v_last = (vpos == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else if (h_last) begin
      hpos <= '0;
      vpos <= v_last ? '0 : vpos + CNT_W'(1);
    end else begin
      hpos <= hpos + CNT_W'(1);
    end
  end

  always_comb begin
    active = (hpos < H_VIS) && (vpos < V_VIS);
    hsync  = ~((hpos >= HS_FROM) && (hpos < HS_TO));
    vsync  = ~((vpos >= VS_FROM) && (vpos < VS_TO));
    fb     = h_last && v_last;
    first  = (hpos == '0) && (vpos == '0);
  end

endmodule

// File: rtl/gradient_scanner.sv
// Raster scan front end: adds the per-frame animation offset and pattern latch
// to the beam timing and registers ROM address, display enable and syncs together.
module gradient_scanner
  import gradient_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SW    = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       anim_en,
  output logic [6:0] grad_y,
  output logic [1:0] grad_x,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  logic [CNT_W-1:0]   hpos;
  logic [CNT_W-1:0]   vpos;
  logic               active;
  logic               hsync_c;
  logic               vsync_c;
  logic               fb;
  logic               first;
  logic [LEVEL_W-1:0] offset;
  logic [1:0]         mode_q;
  logic [LEVEL_W-1:0] level;
  pix_out_t           pix_d;
  pix_out_t           pix_q;

  vga_timing #(
    .H_ACT   (H_ACT),
    .H_FRONT (H_FRONT),
    .H_SW    (H_SW),
    .H_BACK  (H_BACK),
    .V_ACT   (V_ACT),
    .V_FRONT (V_FRONT),
    .V_SW    (V_SW),
    .V_BACK  (V_BACK)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .hpos   (hpos),
    .vpos   (vpos),
    .active (active),
    .hsync  (hsync_c),
    .vsync  (vsync_c),
    .fb     (fb),
    .first  (first)
  );

  // Offset and pattern change together only at the frame boundary, so a
  // frame is always drawn with one consistent pair of values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
      mode_q <= MODE_VERT;
    end else if (fb) begin
      if (anim_en) begin
        offset <= offset + LEVEL_W'(1);
      end
      mode_q <= mode;
    end
  end

  assign level = calc_level(mode_q, hpos, vpos, offset);

  // Blanking drives ROM address 0, which the ROM maps to black.
  always_comb begin
    pix_d            = PIX_RST;
    pix_d.de         = active;
    pix_d.hsync      = hsync_c;
    pix_d.vsync      = vsync_c;
    pix_d.frame_tick = first;
    if (active) begin
      pix_d.grad_y = {level, vpos[0]};
      pix_d.grad_x = hpos[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= PIX_RST;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign grad_y     = pix_q.grad_y;
  assign grad_x     = pix_q.grad_x;
  assign de         = pix_q.de;
  assign hsync      = pix_q.hsync;
  assign vsync      = pix_q.vsync;
  assign frame_tick = pix_q.frame_tick;

endmodule

// File: tb/tb_gradient_scanner.sv
// Bench for gradient_scanner: a full 640x480 instance and a shrunken-timing
// instance share stimulus and are both compared every clock against a pixel model.
module tb_gradient_scanner;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       anim_en;

  logic [6:0] gy_f, gy_s;
  logic [1:0] gx_f, gx_s;
  logic       de_f, de_s, hs_f, hs_s, vs_f, vs_s, ft_f, ft_s;
  logic [13:0] out_f, out_s;

  int total;
  int bad;

  // model state, index 0 = full timing, 1 = small timing
  int mh[2], mv[2], moff[2], mmd[2];
  int ha[2], hss[2], hse[2], ht[2];
  int va[2], vss[2], vse[2], vt[2];

  localparam logic [13:0] RST_OUT = {7'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gradient_scanner dut_full (
    .clk(clk), .rst_n(rst_n), .mode(mode), .anim_en(anim_en),
    .grad_y(gy_f), .grad_x(gx_f), .de(de_f), .hsync(hs_f), .vsync(vs_f),
    .frame_tick(ft_f)
  );

  gradient_scanner #(
    .H_ACT(16), .H_FRONT(2), .H_SW(4), .H_BACK(2),
    .V_ACT(12), .V_FRONT(1), .V_SW(2), .V_BACK(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .mode(mode), .anim_en(anim_en),
    .grad_y(gy_s), .grad_x(gx_s), .de(de_s), .hsync(hs_s), .vsync(vs_s),
    .frame_tick(ft_s)
  );

  assign out_f = {gy_f, gx_f, de_f, hs_f, vs_f, ft_f};
  assign out_s = {gy_s, gx_s, de_s, hs_s, vs_s, ft_s};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
      if (bad >= 50) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  // Expected registered outputs for the model's current beam position.
  function automatic logic [13:0] model_out(input int k);
    int h, v, lvl, gy, gx;
    bit act, hs, vs, ft;
    h = mh[k];
    v = mv[k];
    act = (h < ha[k]) && (v < va[k]);
    case (mmd[k])
      0:       lvl = (v / 8) % 64 + moff[k];
      1:       lvl = h / 16 + moff[k];
      2:       lvl = h / 16 + v / 16 + moff[k];
      default: lvl = moff[k];
    endcase
    lvl = lvl % 64;
    gy = act ? lvl * 2 + v % 2 : 0;
    gx = act ? h % 4 : 0;
    hs = !(h >= hss[k] && h < hse[k]);
    vs = !(v >= vss[k] && v < vse[k]);
    ft = (h == 0) && (v == 0);
    return {7'(gy), 2'(gx), act, hs, vs, ft};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; moff[k] = 0; mmd[k] = 0;
    end
  endtask

  // driver: one clock; compare both instances, then advance the model
  task automatic step();
    logic [1:0] md_edge;
    logic       an_edge;
    logic       rst_edge;
    logic [13:0] got;
    md_edge  = mode;
    an_edge  = anim_en;
    rst_edge = rst_n;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      got = (k == 0) ? out_f : out_s;
      if (!rst_edge) begin
        check(k == 0 ? "rst_hold_full" : "rst_hold_small", 32'(got), 32'(RST_OUT));
      end else begin
        check(k == 0 ? "pix_full" : "pix_small", 32'(got), 32'(model_out(k)));
        if (k == 0 && mv[0] == 17 && mh[0] == 0 && mmd[0] == 0 && moff[0] == 0)
          check("row17_grad_y", 32'(gy_f), 32'd5);
        if (k == 1 && mmd[1] == 3 && mv[1] == 1 && mh[1] == 0)
          check("fade_grad_y", 32'(gy_s), 32'(moff[1] * 2 + 1));
        if (mh[k] == ht[k] - 1) begin
          mh[k] = 0;
          if (mv[k] == vt[k] - 1) begin
            mv[k] = 0;
            if (an_edge) moff[k] = (moff[k] + 1) % 64;
            mmd[k] = int'(md_edge);
          end else begin
            mv[k]++;
          end
        end else begin
          mh[k]++;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_small(input int v, input int h);
    int n;
    n = 0;
    while (!(mv[1] == v && mh[1] == h) && n < 2000) begin
      step();
      n++;
    end
    check("wait_small_pos", 32'(n < 2000), 32'd1);
  endtask

  // asynchronous assertion between edges; outputs must drop at once
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_full", 32'(out_f), 32'(RST_OUT));
    check("async_rst_small", 32'(out_s), 32'(RST_OUT));
    model_reset();
    run(3);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    ha[0] = 640; hss[0] = 656; hse[0] = 752; ht[0] = 800;
    va[0] = 480; vss[0] = 490; vse[0] = 492; vt[0] = 525;
    ha[1] = 16;  hss[1] = 18;  hse[1] = 22;  ht[1] = 24;
    va[1] = 12;  vss[1] = 13;  vse[1] = 15;  vt[1] = 16;
    model_reset();
    rst_n = 1'b0;
    mode = 2'd0;
    anim_en = 1'b0;

    run(4);
    rst_n = 1'b1;
    step();
    check("first_tick", 32'(ft_f), 32'd1);
    check("first_de", 32'(de_f), 32'd1);
    check("first_grad_y", 32'(gy_f), 32'd0);
    check("first_hsync", 32'(hs_f), 32'd1);
    run(16500);

    // flat fade with animation across a full offset wrap on the small raster
    mode = 2'd3;
    anim_en = 1'b1;
    run(65 * 384);

    // mid-frame pattern switch and a lone mid-frame anim pulse
    mode = 2'd0;
    anim_en = 1'b0;
    run(2 * 384);
    wait_small(5, 3);
    mode = 2'd2;
    anim_en = 1'b1;
    step();
    anim_en = 1'b0;
    run(2 * 384);

    // random pattern and animation control
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      anim_en = 1'($urandom_range(0, 1));
      step();
    end

    // reset in the middle of a frame
    anim_en = 1'b1;
    mode = 2'd1;
    wait_small(8, 7);
    async_reset();
    run(3 * 384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
